// File: rtl/riscv_divider_if.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_divider_if
//  Brief    : Divide request/response bundle between the execute-stage
//             integer compute unit (master) and the divider (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface riscv_divider_if #(
    parameter int WIDTH = 64
);
    logic             i_riscv_div_start;
    logic             i_riscv_div_kill;
    logic [2:0]       i_riscv_div_divctrl;
    logic             i_riscv_div_word;
    logic [WIDTH-1:0] i_riscv_div_rs1data;
    logic [WIDTH-1:0] i_riscv_div_rs2data;
    logic             o_riscv_div_busy;
    logic             o_riscv_div_valid;
    logic [WIDTH-1:0] o_riscv_div_result;

    // Requester side: issues operations, observes busy/valid/result.
    modport master (
        output i_riscv_div_start, i_riscv_div_kill, i_riscv_div_divctrl,
        output i_riscv_div_word, i_riscv_div_rs1data, i_riscv_div_rs2data,
        input  o_riscv_div_busy, o_riscv_div_valid, o_riscv_div_result
    );

    // Divider side.
    modport slave (
        input  i_riscv_div_start, i_riscv_div_kill, i_riscv_div_divctrl,
        input  i_riscv_div_word, i_riscv_div_rs1data, i_riscv_div_rs2data,
        output o_riscv_div_busy, o_riscv_div_valid, o_riscv_div_result
    );
endinterface
`default_nettype wire

// File: rtl/riscv_divider.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_divider
//  Brief    : Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU
//             and their W variants. One quotient bit per cycle; divide by
//             zero and signed overflow complete without iterating.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_divider #(
    parameter int WIDTH = 64
) (
    input  wire logic      i_riscv_div_clk,
    input  wire logic      i_riscv_div_rst,
    riscv_divider_if.slave bus
);
    localparam int c_HALF  = WIDTH / 2;
    localparam int c_CNT_W = $clog2(WIDTH);

    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(c_HALF - 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_BUSY = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic               r_valid;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_quo;      // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0]   r_rem;      // partial remainder, always < r_div between steps
    logic [WIDTH-1:0]   r_div;      // divisor magnitude
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_sign_q;
    logic               r_sign_r;
    logic               r_rem_sel;
    logic               r_word;

    logic               w_unsigned;
    logic               w_word;
    logic [WIDTH-1:0]   w_a_ext;
    logic [WIDTH-1:0]   w_b_ext;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH-1:0]   w_dividend_init;
    logic               w_div_zero;
    logic               w_ovf;
    logic               w_accept;
    logic [WIDTH-1:0]   w_spec_res;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_sub;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [WIDTH-1:0]   w_fin_res;

    // Apply sign corrections, pick quotient or remainder, sign-extend W results.
    function automatic logic [WIDTH-1:0] f_finalize(
        input logic [WIDTH-1:0] quo,
        input logic [WIDTH-1:0] rem,
        input logic             sign_q,
        input logic             sign_r,
        input logic             rem_sel,
        input logic             word
    );
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] s;
        q = sign_q ? -quo : quo;
        r = sign_r ? -rem : rem;
        s = rem_sel ? r : q;
        return word ? {{c_HALF{s[c_HALF-1]}}, s[c_HALF-1:0]} : s;
    endfunction

    assign w_unsigned = bus.i_riscv_div_divctrl[0];
    assign w_word     = bus.i_riscv_div_word;

    // W ops see only the low half of each operand, extended per signedness.
    assign w_a_ext = !w_word ? bus.i_riscv_div_rs1data :
                     w_unsigned ? {{c_HALF{1'b0}}, bus.i_riscv_div_rs1data[c_HALF-1:0]} :
                     {{c_HALF{bus.i_riscv_div_rs1data[c_HALF-1]}}, bus.i_riscv_div_rs1data[c_HALF-1:0]};
    assign w_b_ext = !w_word ? bus.i_riscv_div_rs2data :
                     w_unsigned ? {{c_HALF{1'b0}}, bus.i_riscv_div_rs2data[c_HALF-1:0]} :
                     {{c_HALF{bus.i_riscv_div_rs2data[c_HALF-1]}}, bus.i_riscv_div_rs2data[c_HALF-1:0]};

    assign w_a_neg = !w_unsigned && w_a_ext[WIDTH-1];
    assign w_b_neg = !w_unsigned && w_b_ext[WIDTH-1];
    assign w_a_abs = w_a_neg ? -w_a_ext : w_a_ext;
    assign w_b_abs = w_b_neg ? -w_b_ext : w_b_ext;

    // A W dividend is parked in the upper half so 32 shifts consume exactly it.
    assign w_dividend_init = w_word ? {w_a_abs[c_HALF-1:0], {c_HALF{1'b0}}} : w_a_abs;

    assign w_div_zero = (w_b_ext == '0);
    assign w_ovf      = !w_unsigned && (w_b_ext == '1) &&
                        (w_word ? (w_a_ext[c_HALF-1:0] == {1'b1, {(c_HALF-1){1'b0}}})
                                : (w_a_ext == {1'b1, {(WIDTH-1){1'b0}}}));

    // Kill outranks start; a start is only looked at when not iterating.
    assign w_accept = bus.i_riscv_div_start && bus.i_riscv_div_divctrl[2] &&
                      !bus.i_riscv_div_kill && (r_state != c_S_BUSY);

    // Special cases are already in final form, so no sign fix is applied.
    assign w_spec_res = f_finalize(w_div_zero ? '1 : w_a_ext,
                                   w_div_zero ? w_a_ext : '0,
                                   1'b0, 1'b0, bus.i_riscv_div_divctrl[1], w_word);

    // One restoring step; the shifted remainder needs an extra top bit.
    assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_div});
    assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_div;
    assign w_rem_nxt = w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
    assign w_fin_res = f_finalize(w_quo_nxt, w_rem_nxt, r_sign_q, r_sign_r, r_rem_sel, r_word);

    // Control FSM plus datapath: accept/prepare, iterate, publish result.
    always_ff @(posedge i_riscv_div_clk) begin
        if (i_riscv_div_rst) begin
            r_state   <= c_S_IDLE;
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            r_cnt     <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_rem_sel <= 1'b0;
            r_word    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                c_S_BUSY: begin
                    if (bus.i_riscv_div_kill) begin
                        r_state <= c_S_IDLE;
                    end else begin
                        r_quo <= w_quo_nxt;
                        r_rem <= w_rem_nxt;
                        if (r_cnt == '0) begin
                            r_state  <= c_S_DONE;
                            r_valid  <= 1'b1;
                            r_result <= w_fin_res;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_rem_sel <= bus.i_riscv_div_divctrl[1];
                        r_word    <= w_word;
                        r_sign_q  <= w_a_neg ^ w_b_neg;
                        r_sign_r  <= w_a_neg;
                        r_div     <= w_b_abs;
                        r_rem     <= '0;
                        r_quo     <= w_dividend_init;
                        r_cnt     <= w_word ? c_CNT_HALF : c_CNT_FULL;
                        if (w_div_zero || w_ovf) begin
                            r_state  <= c_S_DONE;
                            r_valid  <= 1'b1;
                            r_result <= w_spec_res;
                        end else begin
                            r_state <= c_S_BUSY;
                        end
                    end else begin
                        r_state <= c_S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.o_riscv_div_busy   = (r_state == c_S_BUSY);
    assign bus.o_riscv_div_valid  = r_valid && !bus.i_riscv_div_kill;
    assign bus.o_riscv_div_result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_riscv_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_divider
//  Brief    : Self-checking bench for riscv_divider: directed vector table
//             plus hand-written kill / reset / back-to-back sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_divider;
    localparam int c_W = 64;

    typedef struct {
        logic [2:0]  ctrl;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    vec_t vecs[24];

    riscv_divider_if #(.WIDTH(c_W)) bus ();

    riscv_divider #(.WIDTH(c_W)) dut (
        .i_riscv_div_clk (clk),
        .i_riscv_div_rst (rst),
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time bound so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic start, input logic [2:0] ctrl, input logic word,
                         input logic [63:0] a, input logic [63:0] b);
        bus.i_riscv_div_start   = start;
        bus.i_riscv_div_divctrl = ctrl;
        bus.i_riscv_div_word    = word;
        bus.i_riscv_div_rs1data = a;
        bus.i_riscv_div_rs2data = b;
    endtask

    task automatic scramble();
        drive(1'b0, {1'b1, 2'($urandom)}, 1'($urandom),
              {$urandom(), $urandom()}, {$urandom(), $urandom()});
    endtask

    // Called at the negedge of cycle 1; polls valid, pokes a stray start mid-op.
    task automatic wait_valid(input int limit, output int cyc, output bit seen);
        cyc  = 1;
        seen = 1'b0;
        while (cyc <= limit && !seen) begin
            if (bus.o_riscv_div_valid) begin
                seen = 1'b1;
            end else begin
                if (cyc == 3) bus.i_riscv_div_start = 1'b1;
                if (cyc == 4) bus.i_riscv_div_start = 1'b0;
                @(negedge clk);
                cyc++;
            end
        end
        bus.i_riscv_div_start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        bit seen;
        @(negedge clk);
        drive(1'b1, v.ctrl, v.word, v.a, v.b);
        @(negedge clk);
        scramble();
        if (v.lat > 1) chk($sformatf("v%0d busy@1", idx), 64'(bus.o_riscv_div_busy), 64'd1);
        wait_valid(200, cyc, seen);
        chk($sformatf("v%0d valid seen", idx), 64'(seen), 64'd1);
        chk($sformatf("v%0d latency", idx), 64'(cyc), 64'(v.lat));
        chk($sformatf("v%0d result", idx), bus.o_riscv_div_result, v.exp);
        @(negedge clk);
        chk($sformatf("v%0d valid pulse end", idx), 64'(bus.o_riscv_div_valid), 64'd0);
    endtask

    initial begin
        int cyc;
        bit seen;
        int pulses;
        n_cmp  = 0;
        n_fail = 0;
        bus.i_riscv_div_kill = 1'b0;
        drive(1'b0, 3'b000, 1'b0, 64'd0, 64'd0);

        //            ctrl    w     rs1                    rs2                    expected               lat
        vecs[0]  = '{3'b101, 1'b0, 64'd100,               64'd7,                 64'd14,                65};
        vecs[1]  = '{3'b110, 1'b0, -64'sd7,               64'd2,                 64'hFFFFFFFFFFFFFFFF,  65};
        vecs[2]  = '{3'b100, 1'b0, -64'sd7,               64'd2,                 64'hFFFFFFFFFFFFFFFD,  65};
        vecs[3]  = '{3'b100, 1'b0, 64'd7,                 -64'sd2,               64'hFFFFFFFFFFFFFFFD,  65};
        vecs[4]  = '{3'b110, 1'b0, 64'd7,                 -64'sd2,               64'd1,                 65};
        vecs[5]  = '{3'b100, 1'b0, 64'd42,                64'd0,                 64'hFFFFFFFFFFFFFFFF,  1};
        vecs[6]  = '{3'b111, 1'b0, 64'd42,                64'd0,                 64'd42,                1};
        vecs[7]  = '{3'b100, 1'b0, 64'h8000000000000000,  64'hFFFFFFFFFFFFFFFF,  64'h8000000000000000,  1};
        vecs[8]  = '{3'b110, 1'b0, 64'h8000000000000000,  64'hFFFFFFFFFFFFFFFF,  64'd0,                 1};
        vecs[9]  = '{3'b101, 1'b1, 64'h00000000FFFFFFFE,  64'd1,                 64'hFFFFFFFFFFFFFFFE,  33};
        vecs[10] = '{3'b110, 1'b1, 64'h0000000123456789,  64'h10,                64'd9,                 33};
        vecs[11] = '{3'b100, 1'b1, 64'h12345678FFFFFFEC,  64'd3,                 64'hFFFFFFFFFFFFFFFA,  33};
        vecs[12] = '{3'b111, 1'b1, 64'hDEADBEEF00000011,  64'hFFFF000000000005,  64'd2,                 33};
        vecs[13] = '{3'b101, 1'b1, 64'h0000000080000001,  64'hABCD000100000000,  64'hFFFFFFFFFFFFFFFF,  1};
        vecs[14] = '{3'b110, 1'b1, 64'hAAAAAAAA80000003,  64'h5555555500000000,  64'hFFFFFFFF80000003,  1};
        vecs[15] = '{3'b100, 1'b1, 64'h0000000080000000,  64'h00000000FFFFFFFF,  64'hFFFFFFFF80000000,  1};
        vecs[16] = '{3'b110, 1'b1, 64'h0000000080000000,  64'h00000000FFFFFFFF,  64'd0,                 1};
        vecs[17] = '{3'b111, 1'b0, 64'hFFFFFFFFFFFFFFFF,  64'h10,                64'hF,                 65};
        vecs[18] = '{3'b101, 1'b0, 64'hFFFFFFFFFFFFFFFF,  64'd1,                 64'hFFFFFFFFFFFFFFFF,  65};
        vecs[19] = '{3'b101, 1'b0, 64'hFFFFFFFFFFFFFFFF,  64'h8000000000000000,  64'd1,                 65};
        vecs[20] = '{3'b111, 1'b0, 64'hFFFFFFFFFFFFFFFF,  64'h8000000000000000,  64'h7FFFFFFFFFFFFFFF,  65};
        vecs[21] = '{3'b100, 1'b0, 64'h8000000000000000,  64'd2,                 64'hC000000000000000,  65};
        vecs[22] = '{3'b101, 1'b0, 64'd9,                 64'd3,                 64'd3,                 65};
        vecs[23] = '{3'b110, 1'b1, 64'h00000000FFFFFFF9,  64'd2,                 64'hFFFFFFFFFFFFFFFF,  33};

        // Reset state.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(bus.o_riscv_div_busy), 64'd0);
        chk("reset valid", 64'(bus.o_riscv_div_valid), 64'd0);
        chk("reset result", bus.o_riscv_div_result, 64'd0);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Back-to-back: new start accepted in the DONE cycle of a special case.
        @(negedge clk);
        drive(1'b1, 3'b100, 1'b0, 64'd42, 64'd0);
        @(negedge clk);
        chk("b2b first valid", 64'(bus.o_riscv_div_valid), 64'd1);
        chk("b2b first result", bus.o_riscv_div_result, 64'hFFFFFFFFFFFFFFFF);
        drive(1'b1, 3'b101, 1'b0, 64'd100, 64'd7);
        @(negedge clk);
        scramble();
        chk("b2b second busy", 64'(bus.o_riscv_div_busy), 64'd1);
        wait_valid(200, cyc, seen);
        chk("b2b second seen", 64'(seen), 64'd1);
        chk("b2b second latency", 64'(cyc), 64'd65);
        chk("b2b second result", bus.o_riscv_div_result, 64'd14);

        // Kill at cycle 10 of a DIV: no valid, busy drops, result holds 14.
        @(negedge clk);
        drive(1'b1, 3'b100, 1'b0, 64'd1000, 64'd3);
        @(negedge clk);
        scramble();
        pulses = 0;
        for (int c = 1; c < 10; c++) begin
            if (bus.o_riscv_div_valid) pulses++;
            @(negedge clk);
        end
        bus.i_riscv_div_kill = 1'b1;
        @(negedge clk);
        bus.i_riscv_div_kill = 1'b0;
        chk("kill busy@11", 64'(bus.o_riscv_div_busy), 64'd0);
        for (int c = 0; c < 80; c++) begin
            if (bus.o_riscv_div_valid) pulses++;
            @(negedge clk);
        end
        chk("kill no valid", 64'(pulses), 64'd0);
        chk("kill result held", bus.o_riscv_div_result, 64'd14);
        run_vec(vecs[22], 100);

        // Kill beats a simultaneous start.
        @(negedge clk);
        drive(1'b1, 3'b101, 1'b0, 64'd50, 64'd5);
        bus.i_riscv_div_kill = 1'b1;
        @(negedge clk);
        bus.i_riscv_div_kill = 1'b0;
        drive(1'b0, 3'b000, 1'b0, 64'd0, 64'd0);
        chk("kill+start busy", 64'(bus.o_riscv_div_busy), 64'd0);
        chk("kill+start valid", 64'(bus.o_riscv_div_valid), 64'd0);

        // Start with the op-enable bit clear is ignored (would be a 1-cycle special).
        @(negedge clk);
        drive(1'b1, 3'b001, 1'b0, 64'd5, 64'd0);
        @(negedge clk);
        drive(1'b0, 3'b000, 1'b0, 64'd0, 64'd0);
        chk("disabled busy", 64'(bus.o_riscv_div_busy), 64'd0);
        chk("disabled valid", 64'(bus.o_riscv_div_valid), 64'd0);

        // Kill during DONE suppresses the valid pulse.
        @(negedge clk);
        drive(1'b1, 3'b100, 1'b0, 64'd42, 64'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 3'b000, 1'b0, 64'd0, 64'd0);
        bus.i_riscv_div_kill = 1'b1;
        @(negedge clk);
        chk("kill in done valid", 64'(bus.o_riscv_div_valid), 64'd0);
        @(negedge clk);
        bus.i_riscv_div_kill = 1'b0;
        chk("kill in done after", 64'(bus.o_riscv_div_valid), 64'd0);

        // Reset while BUSY: everything clears, no valid afterwards.
        @(negedge clk);
        drive(1'b1, 3'b101, 1'b0, 64'd100, 64'd7);
        @(negedge clk);
        scramble();
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid reset busy", 64'(bus.o_riscv_div_busy), 64'd0);
        chk("mid reset valid", 64'(bus.o_riscv_div_valid), 64'd0);
        chk("mid reset result", bus.o_riscv_div_result, 64'd0);
        pulses = 0;
        for (int c = 0; c < 80; c++) begin
            if (bus.o_riscv_div_valid) pulses++;
            @(negedge clk);
        end
        chk("mid reset no valid", 64'(pulses), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/riscv_divider.md
Name: riscv_divider

Overview:
- Iterative radix-2 restoring divider; the responder side of the execute-stage integer compute unit's divide request/valid handshake.
- Accepts a single-cycle start with operands and divctrl.
- Runs one quotient bit per cycle.
- Returns quotient or remainder with a one-cycle valid pulse.
- Covers all RV64M divide ops: DIV/DIVU/REM/REMU and the W variants.

Parameters:
- width, 64, operand/result width (XLEN); word ops operate on width/2.

Ports:
- i_riscv_div_clk  input  1  clock.
- i_riscv_div_rst  input  1  synchronous, active-high reset.
- i_riscv_div_start  input  1  request pulse; sampled only when not BUSY.
- i_riscv_div_kill  input  1  pipeline flush; abandons the operation in flight.
- i_riscv_div_divctrl  input  3  [2]=op enable, [1]=1 REM / 0 DIV, [0]=1 unsigned / 0 signed.
- i_riscv_div_word  input  1  1 = W variant (32-bit op, sign-extended result).
- i_riscv_div_rs1data  input  width  dividend.
- i_riscv_div_rs2data  input  width  divisor.
- o_riscv_div_busy  output  1  high while in BUSY.
- o_riscv_div_valid  output  1  one-cycle pulse; result is valid in that cycle.
- o_riscv_div_result  output  width  quotient or remainder; held until the next accepted start.

Behaviour:
- Interface:
  - One clock. Reset is synchronous and active-high.
  - i_riscv_div_clk / i_riscv_div_rst follow the codebase naming.
- Reset:
  - state=IDLE; busy=0, valid=0, result=0.
  - All internal registers cleared.
  - Reset in BUSY aborts with no valid.
- Acceptance:
  - A start is accepted when start=1, divctrl[2]=1 and state is IDLE or DONE.
  - start with divctrl[2]=0 is ignored.
  - start during BUSY is ignored; the requester must wait for !busy.
- Operand preparation, on the accept cycle:
  - Word ops: take low 32 bits of each operand, sign-extend (signed) or zero-extend (unsigned).
  - Signed ops: record sign_q = sign(a) XOR sign(b) and sign_r = sign(a); divide absolute values.
  - Iteration count N = 32 for word ops, 64 otherwise.
- Special cases, decided on the accept cycle; these skip BUSY and go straight to DONE:
  - Divisor == 0:
    - quotient = all ones.
    - remainder = dividend (W: sign-extended low 32 bits).
  - Signed overflow, i.e. most-negative / -1 (64-bit, or 0x80000000 for W):
    - quotient = dividend (W: 0xFFFFFFFF80000000).
    - remainder = 0.
  - Latency for these: valid in cycle +1.
- States:
  - IDLE: on accept, go to BUSY with counter=N-1, or to DONE for a special case.
  - BUSY, one step per cycle:
    - Shift {rem,quo} left by 1.
    - If rem >= divisor, subtract the divisor and set quo[0]=1.
    - When counter==0, go to DONE; otherwise decrement the counter.
  - DONE:
    - Apply sign fixes: negate quotient if sign_q, negate remainder if sign_r.
    - Select quotient/remainder by divctrl[1]. W: sign-extend bit 31 of the selection.
    - Register result; valid=1 for exactly this cycle.
    - Next state is IDLE, or a new accept (back-to-back is allowed).
- Latency:
  - Normal ops: valid at cycle N+1 after the accept cycle (65 for 64-bit, 33 for W).
- Kill:
  - Kill in BUSY: go to IDLE next cycle; no valid; result unchanged.
  - Kill in DONE suppresses valid.
  - Kill has priority over a simultaneous start.
- Control latching:
  - divctrl, word and operands are latched at accept.
  - Input changes during BUSY have no effect.

Test Plan:
- DIVU 64-bit: rs1=100, rs2=7 -> valid at cycle 65; result=14; busy high for cycles 1-64.
- REM signed: rs1=-7, rs2=2 -> result=-1 (0xFFFFFFFFFFFFFFFF). DIV with the same operands -> -3.
- Divide by zero:
  - DIV rs1=42, rs2=0 -> valid at cycle 1, result=0xFFFFFFFFFFFFFFFF.
  - REMU with the same operands -> 42.
- Overflow: DIV rs1=0x8000000000000000, rs2=-1 -> cycle 1, result=0x8000000000000000. REM -> 0.
- W ops:
  - DIVUW rs1=0x00000000FFFFFFFE, rs2=1 -> valid at cycle 33, result=0xFFFFFFFFFFFFFFFE.
  - REMW rs1=0x123456789 (low 32 bits = 0x23456789), rs2=0x10 -> result=0x9.
- Kill/reset:
  - Assert kill at cycle 10 of a DIV -> no valid; busy low at cycle 11.
  - New DIVU 9/3 -> result=3.
  - Reset mid-BUSY -> all outputs 0 next cycle.
